// File: rtl/camera_bus_emitter_if.sv
// camera_bus_emitter_if
//   Groups the pixel-source handshake and the DVP-style camera bus of
//   camera_bus_emitter into one bundle.
//   master : the emitter (takes pixels, drives the camera bus)
//   slave  : the environment (supplies pixels, watches the bus)
//   Signals: pixel_in[23:0] {R,G,B}, pixel_valid_in, pixel_ready_out,
//            pclk_out, vsync_out, href_out, data_out[7:0],
//            frame_done_out, underflow_out
interface camera_bus_emitter_if;
  logic [23:0] pixel_in;
  logic        pixel_valid_in;
  logic        pixel_ready_out;
  logic        pclk_out;
  logic        vsync_out;
  logic        href_out;
  logic [7:0]  data_out;
  logic        frame_done_out;
  logic        underflow_out;

  modport master (
    input  pixel_in, pixel_valid_in,
    output pixel_ready_out, pclk_out, vsync_out, href_out, data_out,
           frame_done_out, underflow_out
  );

  modport slave (
    output pixel_in, pixel_valid_in,
    input  pixel_ready_out, pclk_out, vsync_out, href_out, data_out,
           frame_done_out, underflow_out
  );
endinterface

// File: rtl/camera_bus_emitter.sv
// camera_bus_emitter
//   Replays RGB888 pixel words from a valid/ready source as a DVP-style
//   byte bus (pclk, vsync, href, data) with fixed frame timing. Everything
//   runs on clk_in; pclk_out is clk_in/2 and bus outputs change only on
//   the falling edge of pclk_out (edges where phase == 1).
//
//   Optional feature macro: CAM_BUS_RGB888_EN
//     undefined : 2 bytes per pixel, RGB565 high byte first
//     defined   : 3 bytes per pixel, R, G, B unpacked
//
//   Ports:
//     clk_in  - sole clock
//     rst_in  - synchronous active-high reset
//     bus     - camera_bus_emitter_if.master (pixel handshake + camera bus)
module camera_bus_emitter #(
  parameter int H_ACTIVE      = 32,
  parameter int H_BLANK       = 8,
  parameter int V_ACTIVE      = 2,
  parameter int VSYNC_SLOTS   = 16,
  parameter int V_PORCH_SLOTS = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  camera_bus_emitter_if.master  bus
);

`ifdef CAM_BUS_RGB888_EN
  localparam int BPP = 3;
`else
  localparam int BPP = 2;
`endif

  // One shared slot counter serves VSYNC, VPORCH and HBLANK.
  localparam int SLOT_MAX = (VSYNC_SLOTS > V_PORCH_SLOTS)
                          ? ((VSYNC_SLOTS > H_BLANK) ? VSYNC_SLOTS : H_BLANK)
                          : ((V_PORCH_SLOTS > H_BLANK) ? V_PORCH_SLOTS : H_BLANK);
  localparam int SW = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
  localparam int PW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BW = $clog2(BPP);

  localparam logic [SW-1:0] VS_LAST = SW'(VSYNC_SLOTS - 1);
  localparam logic [SW-1:0] VP_LAST = SW'(V_PORCH_SLOTS - 1);
  localparam logic [SW-1:0] HB_LAST = SW'(H_BLANK - 1);
  localparam logic [PW-1:0] PX_LAST = PW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] LN_LAST = LW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BY_LAST = BW'(BPP - 1);

  typedef enum logic [1:0] {S_VSYNC, S_VPORCH, S_ACTIVE, S_HBLANK} state_e;

  // state/counters describe the slot that the next update edge will emit
  state_e          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [LW-1:0]   line_q, line_d;
  logic [BW-1:0]   byte_q, byte_d;

  logic            phase_q, phase_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            fd_q, fd_d;
  logic            und_q, und_d;
  logic            pend_q, pend_d;   // last HBLANK slot of the frame is on the bus
  logic [23:0]     pix_q, pix_d;

  logic            upd;
  logic [23:0]     take_pix;

  assign upd = phase_q;

  function automatic logic [7:0] pick(input logic [23:0] p, input logic [BW-1:0] idx);
`ifdef CAM_BUS_RGB888_EN
    if (idx == BW'(0)) return p[23:16];
    if (idx == BW'(1)) return p[15:8];
    return p[7:0];
`else
    if (idx == BW'(0)) return {p[23:19], p[15:13]};
    return {p[12:10], p[7:3]};
`endif
  endfunction

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_VSYNC;
      slot_q  <= '0;
      pcnt_q  <= '0;
      line_q  <= '0;
      byte_q  <= '0;
      phase_q <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      fd_q    <= 1'b0;
      und_q   <= 1'b0;
      pend_q  <= 1'b0;
      pix_q   <= 24'h0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      pcnt_q  <= pcnt_d;
      line_q  <= line_d;
      byte_q  <= byte_d;
      phase_q <= phase_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      fd_q    <= fd_d;
      und_q   <= und_d;
      pend_q  <= pend_d;
      pix_q   <= pix_d;
    end
  end

  // Next-state: advance one slot per update edge
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    pcnt_d  = pcnt_q;
    line_d  = line_q;
    byte_d  = byte_q;
    if (upd) begin
      case (state_q)
        S_VSYNC: begin
          if (slot_q == VS_LAST) begin
            slot_d  = '0;
            state_d = S_VPORCH;
          end else slot_d = slot_q + SW'(1);
        end
        S_VPORCH: begin
          if (slot_q == VP_LAST) begin
            slot_d  = '0;
            state_d = S_ACTIVE;
          end else slot_d = slot_q + SW'(1);
        end
        S_ACTIVE: begin
          if (byte_q == BY_LAST) begin
            byte_d = '0;
            if (pcnt_q == PX_LAST) begin
              pcnt_d  = '0;
              state_d = S_HBLANK;
            end else pcnt_d = pcnt_q + PW'(1);
          end else byte_d = byte_q + BW'(1);
        end
        default: begin
          if (slot_q == HB_LAST) begin
            slot_d = '0;
            if (line_q == LN_LAST) begin
              line_d  = '0;
              state_d = S_VSYNC;
            end else begin
              line_d  = line_q + LW'(1);
              state_d = S_ACTIVE;
            end
          end else slot_d = slot_q + SW'(1);
        end
      endcase
    end
  end

  // Outputs: bus values for the slot being emitted, plus handshake
  always_comb begin
    phase_d  = ~phase_q;
    vsync_d  = vsync_q;
    href_d   = href_q;
    data_d   = data_q;
    ready_d  = 1'b0;
    fd_d     = 1'b0;
    und_d    = und_q;
    pend_d   = pend_q;
    pix_d    = pix_q;
    take_pix = 24'h0;
    if (upd) begin
      vsync_d = (state_q == S_VSYNC);
      href_d  = (state_q == S_ACTIVE);
      data_d  = 8'h00;
      // The edge after the final HBLANK slot closes the frame and starts VSYNC.
      fd_d    = pend_q;
      pend_d  = (state_q == S_HBLANK) && (slot_q == HB_LAST) && (line_q == LN_LAST);
      if (state_q == S_ACTIVE) begin
        if (byte_q == '0) begin
          // A missing pixel is replaced by black and flagged.
          if (bus.pixel_valid_in && ready_q) take_pix = bus.pixel_in;
          else                               und_d    = 1'b1;
          pix_d  = take_pix;
          data_d = pick(take_pix, '0);
        end else begin
          data_d = pick(pix_q, byte_q);
        end
      end
    end else begin
      // Counters already point at the coming slot; ready covers the cycle
      // just before the edge that emits byte 0.
      ready_d = (state_q == S_ACTIVE) && (byte_q == '0);
    end
  end

  assign bus.pixel_ready_out = ready_q;
  assign bus.pclk_out        = phase_q;
  assign bus.vsync_out       = vsync_q;
  assign bus.href_out        = href_q;
  assign bus.data_out        = data_q;
  assign bus.frame_done_out  = fd_q;
  assign bus.underflow_out   = und_q;

endmodule

// File: tb/tb_camera_bus_emitter.sv
// Directed bench for camera_bus_emitter with default geometry.
module tb_camera_bus_emitter;
`ifdef CAM_BUS_RGB888_EN
  localparam int BPP = 3;
`else
  localparam int BPP = 2;
`endif
  localparam int FRAME = (16 + 16 + 2 * (32 * BPP + 8)) * 2;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  camera_bus_emitter_if bus();

  camera_bus_emitter #(
    .H_ACTIVE(32), .H_BLANK(8), .V_ACTIVE(2), .VSYNC_SLOTS(16), .V_PORCH_SLOTS(16)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  logic [7:0] e_red[3], e_grn[3], e_blu[3];

  int vs_rise, vs_fall, href_rise, line_bad, blank_bad, href_slots0, fd_cnt, und_drop, waited;
  int fd_t[3];
  int rdy_cnt[3];
  logic vs_prev, href_prev;
  int bidx;

  initial begin
`ifdef CAM_BUS_RGB888_EN
    e_red = '{8'hFF, 8'h00, 8'h00};
    e_grn = '{8'h00, 8'hFF, 8'h00};
    e_blu = '{8'h00, 8'h00, 8'hFF};
`else
    e_red = '{8'hF8, 8'h00, 8'h00};
    e_grn = '{8'h07, 8'hE0, 8'h00};
    e_blu = '{8'h00, 8'h1F, 8'h00};
`endif
    bus.pixel_in       = 24'hFF0000;
    bus.pixel_valid_in = 1'b1;

    // ---- reset state
    tick(); tick(); tick();
    chk("rst_outs", {bus.pclk_out, bus.vsync_out, bus.href_out, bus.data_out,
                     bus.pixel_ready_out, bus.frame_done_out, bus.underflow_out}, 0);

    // ---- three free-running frames of red
    rst_in = 1'b0;
    vs_rise = -1; vs_fall = -1; href_rise = -1;
    line_bad = 0; blank_bad = 0; href_slots0 = 0; fd_cnt = 0; bidx = 0;
    fd_t = '{0, 0, 0};
    rdy_cnt = '{0, 0, 0};
    vs_prev = 1'b0; href_prev = 1'b0;
    for (int t = 1; t <= 3 * FRAME + 4; t++) begin
      tick();
      if (t == 1) chk("pclk_t1", bus.pclk_out, 1);
      if (t == 2) chk("pclk_t2", bus.pclk_out, 0);
      if (bus.vsync_out && !vs_prev && vs_rise < 0) vs_rise = t;
      if (!bus.vsync_out && vs_prev && vs_fall < 0) vs_fall = t;
      if (bus.href_out && !href_prev && href_rise < 0) href_rise = t;
      if (bus.frame_done_out) begin
        if (fd_cnt < 3) fd_t[fd_cnt] = t;
        fd_cnt++;
      end
      if (bus.pixel_ready_out && t >= 2 && (t - 2) / FRAME < 3) rdy_cnt[(t - 2) / FRAME]++;
      if (t % 2 == 0) begin
        if (bus.href_out) begin
          if (bus.data_out !== e_red[bidx]) line_bad++;
          bidx = (bidx == BPP - 1) ? 0 : bidx + 1;
          if (t < 2 + FRAME) href_slots0++;
        end else if (bus.data_out !== 8'h00) blank_bad++;
      end
      vs_prev   = bus.vsync_out;
      href_prev = bus.href_out;
    end
    chk("vsync_rise", vs_rise, 2);
    chk("vsync_fall", vs_fall, 34);
    chk("href_rise", href_rise, 66);
    chk("href_slots_frame0", href_slots0, 2 * 32 * BPP);
    chk("line_data_bad", line_bad, 0);
    chk("blank_data_bad", blank_bad, 0);
    chk("fd_count", fd_cnt, 3);
    chk("fd_t0", fd_t[0], 2 + FRAME);
    chk("fd_t1", fd_t[1], 2 + 2 * FRAME);
    chk("fd_t2", fd_t[2], 2 + 3 * FRAME);
    chk("ready_f0", rdy_cnt[0], 64);
    chk("ready_f1", rdy_cnt[1], 64);
    chk("ready_f2", rdy_cnt[2], 64);
    chk("und_clean", bus.underflow_out, 0);

    // ---- green then blue, back to back
    bus.pixel_in = 24'h00FF00;
    waited = 0;
    while (!bus.pixel_ready_out && waited < 2 * FRAME) begin
      tick();
      waited++;
    end
    chk("ready_wait_timeout", waited < 2 * FRAME, 1);
    tick();
    chk("grn_b0", bus.data_out, e_grn[0]);
    chk("ready_after_take", bus.pixel_ready_out, 0);
    bus.pixel_in = 24'h0000FF;
    for (int k = 1; k < BPP; k++) begin
      tick(); tick();
      chk("grn_bk", bus.data_out, e_grn[k]);
    end
    tick();
    chk("ready_blu", bus.pixel_ready_out, 1);
    tick();
    chk("blu_b0", bus.data_out, e_blu[0]);
    for (int k = 1; k < BPP; k++) begin
      tick(); tick();
      chk("blu_bk", bus.data_out, e_blu[k]);
    end

    // ---- one missed pixel
    bus.pixel_valid_in = 1'b0;
    tick();
    chk("ready_und", bus.pixel_ready_out, 1);
    tick();
    chk("und_byte0", {bus.underflow_out, bus.data_out}, {1'b1, 8'h00});
    bus.pixel_valid_in = 1'b1;
    bus.pixel_in = 24'hFFFFFF;
    for (int k = 1; k < BPP; k++) begin
      tick(); tick();
      chk("und_bytek", bus.data_out, 8'h00);
    end
    tick(); tick();
    chk("white_b0", bus.data_out, 8'hFF);
    und_drop = 0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (!bus.underflow_out) und_drop++;
    end
    chk("und_sticky", und_drop, 0);

    // ---- reset in the middle of a line
    waited = 0;
    while (!bus.href_out && waited < 2 * FRAME) begin
      tick();
      waited++;
    end
    chk("href_wait_timeout", waited < 2 * FRAME, 1);
    tick(); tick(); tick();
    rst_in = 1'b1;
    tick();
    chk("midrst_outs", {bus.pclk_out, bus.vsync_out, bus.href_out, bus.data_out,
                        bus.pixel_ready_out, bus.frame_done_out, bus.underflow_out}, 0);
    rst_in = 1'b0;
    tick();
    chk("midrst_t1", {bus.vsync_out, bus.frame_done_out}, 2'b00);
    tick();
    chk("midrst_t2", {bus.vsync_out, bus.frame_done_out, bus.href_out}, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
